// File: rtl/key_scan_module.sv
// 4x4 matrix keypad scanner: synchronizes the row lines, debounces press and release,
// scans columns one at a time and reports a single key code per accepted press.
module key_scan_module #(
    parameter int unsigned DB_CYCLES = 1000000,
    parameter int unsigned SETTLE    = 500
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic [3:0] Row_In,
    output logic [3:0] Col_Out,
    output logic [3:0] key_value,
    output logic       key_valid,
    output logic       key_down
);

    localparam int unsigned DB_W = $clog2(DB_CYCLES + 1);
    localparam int unsigned ST_W = $clog2(SETTLE + 1);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DB_CYCLES);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(SETTLE - 1);
    localparam logic [ST_W-1:0] ST_MAX  = ST_W'(SETTLE);
    localparam logic [ST_W-1:0] ST_ONE  = ST_W'(1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PRESS_DB = 3'd1;
    localparam logic [2:0] S_SCAN     = 3'd2;
    localparam logic [2:0] S_HOLD     = 3'd3;
    localparam logic [2:0] S_REL_DB   = 3'd4;

    logic [3:0]      meta_r;
    logic [3:0]      rs_r;
    logic [2:0]      state_r;
    logic [2:0]      state_s;
    logic [DB_W-1:0] db_cnt_r;
    logic [DB_W-1:0] db_cnt_s;
    logic [ST_W-1:0] st_cnt_r;
    logic [ST_W-1:0] st_cnt_s;
    logic [1:0]      col_r;
    logic [1:0]      col_s;
    logic [3:0]      col_out_r;
    logic [3:0]      col_out_s;
    logic [3:0]      key_value_r;
    logic [3:0]      key_value_s;
    logic            key_valid_r;
    logic            key_valid_s;
    logic            key_down_r;
    logic            key_down_s;
    logic            rows_idle_s;

    // Lowest-indexed low row wins when several rows are active in one column.
    function automatic logic [1:0] low_row(input logic [3:0] rows);
        logic [1:0] idx;
        if (!rows[0]) begin
            idx = 2'd0;
        end else if (!rows[1]) begin
            idx = 2'd1;
        end else if (!rows[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] c);
        logic [3:0] pat;
        case (c)
            2'd0:    pat = 4'b1110;
            2'd1:    pat = 4'b1101;
            2'd2:    pat = 4'b1011;
            2'd3:    pat = 4'b0111;
            default: pat = 4'b1111;
        endcase
        return pat;
    endfunction

    function automatic logic [DB_W-1:0] db_inc(input logic [DB_W-1:0] v);
        logic [DB_W-1:0] n;
        if (v == DB_MAX) begin
            n = v;
        end else begin
            n = v + DB_ONE;
        end
        return n;
    endfunction

    function automatic logic [ST_W-1:0] st_inc(input logic [ST_W-1:0] v);
        logic [ST_W-1:0] n;
        if (v == ST_MAX) begin
            n = v;
        end else begin
            n = v + ST_ONE;
        end
        return n;
    endfunction

    assign rows_idle_s = (rs_r == 4'hF);

    assign Col_Out   = col_out_r;
    assign key_value = key_value_r;
    assign key_valid = key_valid_r;
    assign key_down  = key_down_r;

    // Two-flop synchronizer for the asynchronous row lines (idle level is all-ones).
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            meta_r <= 4'hF;
            rs_r   <= 4'hF;
        end else begin
            meta_r <= Row_In;
            rs_r   <= meta_r;
        end
    end

    // Next-state and next-output logic for the scan FSM.
    always_comb begin
        state_s     = state_r;
        db_cnt_s    = db_cnt_r;
        st_cnt_s    = st_cnt_r;
        col_s       = col_r;
        col_out_s   = col_out_r;
        key_value_s = key_value_r;
        key_valid_s = 1'b0;
        key_down_s  = key_down_r;
        case (state_r)
            S_IDLE: begin
                col_out_s  = 4'b0000;
                key_down_s = 1'b0;
                if (!rows_idle_s) begin
                    state_s  = S_PRESS_DB;
                    db_cnt_s = '0;
                end else begin
                    state_s  = S_IDLE;
                end
            end
            S_PRESS_DB: begin
                col_out_s = 4'b0000;
                if (rows_idle_s) begin
                    state_s = S_IDLE;
                end else if (db_cnt_r == DB_LAST) begin
                    state_s   = S_SCAN;
                    col_s     = 2'd0;
                    st_cnt_s  = '0;
                    col_out_s = col_drive(2'd0);
                end else begin
                    db_cnt_s = db_inc(db_cnt_r);
                end
            end
            S_SCAN: begin
                // rs lags Col_Out by two cycles, so only the last settle cycle is trusted.
                if (st_cnt_r == ST_LAST) begin
                    if (!rows_idle_s) begin
                        state_s     = S_HOLD;
                        key_value_s = {low_row(rs_r), col_r};
                        key_valid_s = 1'b1;
                        key_down_s  = 1'b1;
                    end else if (col_r == 2'd3) begin
                        state_s   = S_IDLE;
                        col_out_s = 4'b0000;
                    end else begin
                        col_s     = col_r + 2'd1;
                        st_cnt_s  = '0;
                        col_out_s = col_drive(col_r + 2'd1);
                    end
                end else begin
                    st_cnt_s = st_inc(st_cnt_r);
                end
            end
            S_HOLD: begin
                key_down_s = 1'b1;
                if (rows_idle_s) begin
                    state_s  = S_REL_DB;
                    db_cnt_s = '0;
                end else begin
                    state_s  = S_HOLD;
                end
            end
            S_REL_DB: begin
                key_down_s = 1'b1;
                if (!rows_idle_s) begin
                    state_s = S_HOLD;
                end else if (db_cnt_r == DB_LAST) begin
                    state_s    = S_IDLE;
                    key_down_s = 1'b0;
                    col_out_s  = 4'b0000;
                end else begin
                    db_cnt_s = db_inc(db_cnt_r);
                end
            end
            default: begin
                state_s    = S_IDLE;
                col_out_s  = 4'b0000;
                key_down_s = 1'b0;
            end
        endcase
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_r     <= S_IDLE;
            db_cnt_r    <= '0;
            st_cnt_r    <= '0;
            col_r       <= 2'd0;
            col_out_r   <= 4'b0000;
            key_value_r <= 4'h0;
            key_valid_r <= 1'b0;
            key_down_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            db_cnt_r    <= db_cnt_s;
            st_cnt_r    <= st_cnt_s;
            col_r       <= col_s;
            col_out_r   <= col_out_s;
            key_value_r <= key_value_s;
            key_valid_r <= key_valid_s;
            key_down_r  <= key_down_s;
        end
    end

endmodule

// File: tb/tb_key_scan_module.sv
// Directed bench for key_scan_module with DB_CYCLES=4, SETTLE=3 and a behavioural 4x4 keypad.
module tb_key_scan_module;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic [3:0]  Row_In;
    logic [3:0]  Col_Out;
    logic [3:0]  key_value;
    logic        key_valid;
    logic        key_down;

    logic [15:0] keys = 16'h0000;
    int          n_checks = 0;
    int          n_errors = 0;
    int          valid_total = 0;

    key_scan_module #(.DB_CYCLES(4), .SETTLE(3)) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .Row_In    (Row_In),
        .Col_Out   (Col_Out),
        .key_value (key_value),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    always #5 CLK = ~CLK;

    // Keypad: a row reads low when a pressed key joins it to a column driven low.
    always_comb begin
        Row_In = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !Col_Out[c]) Row_In[r] = 1'b0;
            end
        end
    end

    always @(negedge CLK) begin
        if (key_valid === 1'b1) valid_total++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_valid(input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge CLK);
            #1;
            if (key_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        RSTn = 1'b0;
        keys = 16'h0000;
        tick(3);
        n_checks++; if (Col_Out !== 4'b0000) begin n_errors++; $display("FAIL reset_col got=%b exp=0000", Col_Out); end
        n_checks++; if (key_value !== 4'h0) begin n_errors++; $display("FAIL reset_value got=%h exp=0", key_value); end
        n_checks++; if (key_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
        n_checks++; if (key_down !== 1'b0) begin n_errors++; $display("FAIL reset_down got=%b exp=0", key_down); end
        RSTn = 1'b1;
        tick(5);
        n_checks++; if (Col_Out !== 4'b0000) begin n_errors++; $display("FAIL idle_col got=%b exp=0000", Col_Out); end
    endtask

    task automatic test_clean_press;
        int base;
        int lat;
        base = valid_total;
        keys[9] = 1'b1;
        wait_valid(60, lat);
        n_checks++; if (lat < 13 || lat > 15) begin n_errors++; $display("FAIL press_latency got=%0d exp=13..15", lat); end
        n_checks++; if (key_value !== 4'h9) begin n_errors++; $display("FAIL press_value got=%h exp=9", key_value); end
        tick(1);
        n_checks++; if (key_valid !== 1'b0) begin n_errors++; $display("FAIL valid_pulse_width got=%b exp=0", key_valid); end
        tick(26);
        n_checks++; if (valid_total - base !== 1) begin n_errors++; $display("FAIL press_pulse_count got=%0d exp=1", valid_total - base); end
        n_checks++; if (key_down !== 1'b1) begin n_errors++; $display("FAIL hold_down got=%b exp=1", key_down); end
        n_checks++; if (Col_Out !== 4'b1101) begin n_errors++; $display("FAIL hold_col got=%b exp=1101", Col_Out); end
        keys = 16'h0000;
        tick(4);
        n_checks++; if (key_down !== 1'b1) begin n_errors++; $display("FAIL release_db_down got=%b exp=1", key_down); end
        tick(6);
        n_checks++; if (key_down !== 1'b0) begin n_errors++; $display("FAIL released_down got=%b exp=0", key_down); end
        n_checks++; if (Col_Out !== 4'b0000) begin n_errors++; $display("FAIL released_col got=%b exp=0000", Col_Out); end
    endtask

    task automatic test_bounce;
        int base;
        base = valid_total;
        for (int k = 0; k < 5; k++) begin
            keys[5] = 1'b1;
            tick(2);
            keys[5] = 1'b0;
            tick(6);
        end
        tick(10);
        n_checks++; if (valid_total - base !== 0) begin n_errors++; $display("FAIL bounce_pulses got=%0d exp=0", valid_total - base); end
        n_checks++; if (key_value !== 4'h9) begin n_errors++; $display("FAIL bounce_value got=%h exp=9", key_value); end
        n_checks++; if (key_down !== 1'b0) begin n_errors++; $display("FAIL bounce_down got=%b exp=0", key_down); end
    endtask

    task automatic test_two_keys;
        int base;
        int lat;
        base = valid_total;
        keys[3] = 1'b1;
        keys[7] = 1'b1;
        wait_valid(60, lat);
        n_checks++; if (lat < 0) begin n_errors++; $display("FAIL two_keys_timeout got=%0d exp=valid", lat); end
        n_checks++; if (key_value !== 4'h3) begin n_errors++; $display("FAIL two_keys_value got=%h exp=3", key_value); end
        tick(30);
        n_checks++; if (valid_total - base !== 1) begin n_errors++; $display("FAIL two_keys_pulses got=%0d exp=1", valid_total - base); end
        n_checks++; if (Col_Out !== 4'b0111) begin n_errors++; $display("FAIL two_keys_col got=%b exp=0111", Col_Out); end
        keys = 16'h0000;
        tick(15);
        n_checks++; if (key_down !== 1'b0) begin n_errors++; $display("FAIL two_keys_release got=%b exp=0", key_down); end
    endtask

    task automatic test_scan_miss;
        int base;
        base = valid_total;
        keys[14] = 1'b1;
        tick(8);
        keys = 16'h0000;
        tick(30);
        n_checks++; if (valid_total - base !== 0) begin n_errors++; $display("FAIL miss_pulses got=%0d exp=0", valid_total - base); end
        n_checks++; if (key_value !== 4'h3) begin n_errors++; $display("FAIL miss_value got=%h exp=3", key_value); end
        n_checks++; if (key_down !== 1'b0) begin n_errors++; $display("FAIL miss_down got=%b exp=0", key_down); end
        n_checks++; if (Col_Out !== 4'b0000) begin n_errors++; $display("FAIL miss_col got=%b exp=0000", Col_Out); end
    endtask

    task automatic test_release_bounce;
        int base;
        int lat;
        base = valid_total;
        keys[6] = 1'b1;
        wait_valid(60, lat);
        n_checks++; if (key_value !== 4'h6) begin n_errors++; $display("FAIL relb_value got=%h exp=6", key_value); end
        tick(5);
        for (int k = 0; k < 3; k++) begin
            keys[6] = 1'b0;
            tick(2);
            keys[6] = 1'b1;
            tick(1);
        end
        tick(10);
        n_checks++; if (key_down !== 1'b1) begin n_errors++; $display("FAIL relb_down got=%b exp=1", key_down); end
        n_checks++; if (valid_total - base !== 1) begin n_errors++; $display("FAIL relb_pulses got=%0d exp=1", valid_total - base); end
        n_checks++; if (Col_Out !== 4'b1011) begin n_errors++; $display("FAIL relb_col got=%b exp=1011", Col_Out); end
        keys = 16'h0000;
        tick(12);
        n_checks++; if (key_down !== 1'b0) begin n_errors++; $display("FAIL relb_release got=%b exp=0", key_down); end
    endtask

    task automatic test_reset_mid_scan;
        int base;
        int lat;
        keys[15] = 1'b1;
        tick(12);
        RSTn = 1'b0;
        #1;
        n_checks++; if (Col_Out !== 4'b0000) begin n_errors++; $display("FAIL rst_scan_col got=%b exp=0000", Col_Out); end
        n_checks++; if (key_value !== 4'h0) begin n_errors++; $display("FAIL rst_scan_value got=%h exp=0", key_value); end
        n_checks++; if (key_valid !== 1'b0) begin n_errors++; $display("FAIL rst_scan_valid got=%b exp=0", key_valid); end
        n_checks++; if (key_down !== 1'b0) begin n_errors++; $display("FAIL rst_scan_down got=%b exp=0", key_down); end
        keys = 16'h0000;
        tick(2);
        RSTn = 1'b1;
        base = valid_total;
        tick(30);
        n_checks++; if (valid_total - base !== 0) begin n_errors++; $display("FAIL rst_scan_pulses got=%0d exp=0", valid_total - base); end
        keys[15] = 1'b1;
        wait_valid(80, lat);
        n_checks++; if (lat < 19 || lat > 21) begin n_errors++; $display("FAIL col3_latency got=%0d exp=19..21", lat); end
        n_checks++; if (key_value !== 4'hF) begin n_errors++; $display("FAIL col3_value got=%h exp=f", key_value); end
        keys = 16'h0000;
        tick(15);
        n_checks++; if (key_down !== 1'b0) begin n_errors++; $display("FAIL col3_release got=%b exp=0", key_down); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_two_keys();
        test_scan_miss();
        test_release_bounce();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
